cic_decimator: RTL and testbench
================================

# cic_decimator

Third-order CIC (sinc3) decimator converting the 1-bit delta-sigma modulator bitstream into 16-bit PCM samples. It sits between the modulator input pin and the output byte multiplexer. It presents four byte-wide result registers that wire directly to mux inputs d0..d3, so all four bytes are coherent snapshots of one sample.

## Interface
- `ORDER`, 3: CIC order. Fixed; widths below assume 3.
- `ACC_W`, 22: integrator/comb width, 3·log2(128)+1.
- `clk` in, 1: system clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `ena` in, 1: clock enable. Low freezes all state.
- `ds_in` in, 1: modulator bitstream, one bit per clk. 1 = +full scale, 0 = zero.
- `dec_sel` in, 2: decimation ratio R. 00=16, 01=32, 10=64, 11=128.
- `data_lo` out, 8: sample[7:0] (mux d0).
- `data_hi` out, 8: sample[15:8] (mux d1).
- `sample_cnt` out, 8: count of reported samples, mod 256 (mux d2).
- `status` out, 8: bit 7 = warm (first valid sample produced); bit 6 = sat (last sample saturated); bits 5:4 = active dec_sel; bits 3:0 = 0 (mux d3).
- `sample_valid` out, 1: one-cycle pulse when new output bytes are loaded.

## Operation
- All outputs reset to 0x00/0.
- **Integrators:** three cascaded ACC_W-bit integrators, updated every enabled cycle. Input is zero-extended ds_in. Arithmetic is modulo 2^22; wrap-around is intended and must not be detected.
- **Decimation counter:** 7 bits, counts 0..R-1. The tick is the cycle where count == R-1; count returns to 0 after it.
- **Combs:** on each tick, three comb stages (differential delay 1) run at the decimated rate on integrator-3 output. Arithmetic is modulo 2^22.
- **Scaling:** comb output is unsigned, range 0..R^3. Scaling by ratio:
  - R=16: shift left 4.
  - R=32: shift left 1.
  - R=64: shift right 2.
  - R=128: shift right 5.
  - A result ≥ 0x10000 saturates to 0xFFFF and sets status[6] for that sample. status[6] is cleared on the next non-saturated sample.
- **Warm-up:** the first 2 comb outputs after reset or restart are discarded. No register load, no sample_valid, no count change. The third output and later ones are reported. status[7] is set with the first reported sample.
- **Report:** data_lo, data_hi, status and sample_cnt load together on the same edge. sample_cnt increments by 1 per report and wraps 0xFF→0x00.
- **Ratio change (restart):** dec_sel is registered each enabled cycle. If the registered value differs from the active ratio, the block restarts:
  - Clears integrators, combs, counter and warm-up count.
  - Adopts the new ratio and updates status[5:4].
  - Keeps data_lo, data_hi and sample_cnt. Clears status[7].
- **Simultaneous tick and ratio change:** restart wins; that tick's sample is dropped.
- **ena low:** all registers hold. sample_valid is forced 0. A pending pulse is not lost; it is issued on the first enabled cycle.
- **rst_n asserted mid-operation:** all state clears immediately, including in-flight comb results.

## Timing
- Latency: for the input bit sampled at tick cycle T, the output registers load at the edge ending cycle T+1. Bytes are valid from cycle T+2, and sample_valid is high for exactly cycle T+2.
- Output rate: one sample per R enabled cycles.
- Output bytes are stable for the R−1 cycles between reports, so the downstream mux select may change at any time.
- With CIC_SYNC_EN defined, add 2 cycles of input latency.

## Configuration
- `CIC_SYNC_EN` defined: ds_in passes through a two-flop synchronizer (reset 0) before the integrators. Total latency is T+4 relative to the pin.
- Not defined: ds_in feeds integrator 1 directly. The source must be synchronous to clk.

## Test plan
- Reset, then ds_in=1 constant, dec_sel=00:
  - First two ticks give no sample_valid.
  - Third report: data_hi=0xFF, data_lo=0xFF, status=0xC0, sample_cnt=0x01.
- ds_in=0 constant, dec_sel=10: reported samples are 0x0000, status=0xA0.
- Alternating 1,0 pattern, dec_sel=10 (R=64): steady-state sample = 0x8000, status[6]=0.
- Run 258 reports at R=16: sample_cnt reads 0x02 after wrap. sample_valid period is exactly 16 cycles.
- Change dec_sel 00→11 mid-block:
  - status[7] clears and status[5:4]=11.
  - Old data bytes are held.
  - The next sample_valid arrives only after 3×128 cycles.
- Assert rst_n low mid-block: all outputs read 0 in the same cycle. ena low for 50 cycles: outputs and sample_cnt are unchanged.

Source files
------------

// File: rtl/cic_decimator.sv
// -----------------------------------------------------------------------------
// cic_decimator
//
// Third-order CIC (sinc3) decimator: turns the 1-bit delta-sigma bitstream
// into 16-bit PCM samples, presented as four byte-wide registers that feed
// the output byte mux (d0..d3). All four bytes are loaded on the same edge,
// so any byte read between reports belongs to the same sample.
//
// Build option:
//   CIC_SYNC_EN  defined     -> ds_in passes through a two-flop synchronizer
//                               (adds 2 cycles of input latency).
//                not defined -> ds_in feeds integrator 1 directly; the
//                               source must be synchronous to clk.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   ena          in   clock enable; low freezes all state
//   ds_in        in   modulator bitstream (1 = +full scale, 0 = zero)
//   dec_sel[1:0] in   decimation ratio: 00=16, 01=32, 10=64, 11=128
//   data_lo[7:0] out  sample[7:0]                      (mux d0)
//   data_hi[7:0] out  sample[15:8]                     (mux d1)
//   sample_cnt   out  reported samples, mod 256        (mux d2)
//   status[7:0]  out  {warm, sat, active dec_sel, 4'b0} (mux d3)
//   sample_valid out  one-cycle pulse when new bytes are loaded
// -----------------------------------------------------------------------------
module cic_decimator #(
  parameter int ORDER = 3,
  parameter int ACC_W = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       ds_in,
  input  logic [1:0] dec_sel,
  output logic [7:0] data_lo,
  output logic [7:0] data_hi,
  output logic [7:0] sample_cnt,
  output logic [7:0] status,
  output logic       sample_valid
);

  // Width of the scaled comb result: room for the largest left shift (4).
  localparam int SC_W = ACC_W + 4;

  // ---------------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------------
  logic ds_bit;

`ifdef CIC_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
    end else if (ena) begin
      sync_reg <= {sync_reg[0], ds_in};
    end
  end

  assign ds_bit = sync_reg[1];
`else
  assign ds_bit = ds_in;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] integ_reg    [ORDER];
  logic [ACC_W-1:0] integ_next   [ORDER];
  logic [ACC_W-1:0] comb_dly_reg [ORDER];
  logic [ACC_W-1:0] comb_val     [ORDER+1];

  logic [1:0]  dec_sel_reg;      // dec_sel sampled every enabled cycle
  logic [1:0]  act_sel_reg;      // ratio currently in use
  logic [6:0]  count_reg;
  logic [1:0]  warm_cnt_reg;     // comb outputs discarded since (re)start
  logic        pend_reg;         // a reportable sample waits in pend_*
  logic [15:0] pend_sample_reg;
  logic        pend_sat_reg;
  logic [15:0] data_reg;
  logic [7:0]  cnt_reg;
  logic        warm_reg;
  logic        sat_reg;
  logic        valid_reg;

  // ---------------------------------------------------------------------------
  // Integrator chain. Each stage adds the *next* value of the stage before it,
  // so the bit presented in the tick cycle is already inside the value the
  // combs see on that same edge.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < ORDER; gi++) begin : g_integ
      if (gi == 0) begin : g_first
        assign integ_next[gi] = integ_reg[gi] + {{(ACC_W-1){1'b0}}, ds_bit};
      end else begin : g_rest
        assign integ_next[gi] = integ_reg[gi] + integ_next[gi-1];
      end
    end
  endgenerate

  // Comb chain (differential delay 1 at the decimated rate), modulo 2^ACC_W.
  assign comb_val[0] = integ_next[ORDER-1];
  generate
    for (gi = 0; gi < ORDER; gi++) begin : g_comb
      assign comb_val[gi+1] = comb_val[gi] - comb_dly_reg[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Ratio-dependent terminal count and scaling
  // ---------------------------------------------------------------------------
  logic [6:0]      count_max;
  logic [SC_W-1:0] scaled;
  logic [ACC_W-1:0] comb_out;
  logic            scaled_sat;
  logic [15:0]     scaled_sample;

  assign comb_out = comb_val[ORDER];

  always_comb begin
    count_max = 7'd15;
    scaled    = '0;
    case (act_sel_reg)
      2'b00: begin
        count_max = 7'd15;
        scaled    = {comb_out, 4'b0000};
      end
      2'b01: begin
        count_max = 7'd31;
        scaled    = {3'b000, comb_out, 1'b0};
      end
      2'b10: begin
        count_max = 7'd63;
        scaled    = {6'b000000, comb_out[ACC_W-1:2]};
      end
      default: begin
        count_max = 7'd127;
        scaled    = {9'b000000000, comb_out[ACC_W-1:5]};
      end
    endcase
  end

  // Full-scale input lands exactly on 0x10000, hence the saturation.
  assign scaled_sat    = |scaled[SC_W-1:16];
  assign scaled_sample = scaled_sat ? 16'hFFFF : scaled[15:0];

  logic tick;
  logic restart;

  assign tick    = (count_reg == count_max);
  assign restart = (dec_sel_reg != act_sel_reg);

  // ---------------------------------------------------------------------------
  // Sequential core
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ORDER; i++) begin
        integ_reg[i]    <= '0;
        comb_dly_reg[i] <= '0;
      end
      dec_sel_reg     <= 2'b00;
      act_sel_reg     <= 2'b00;
      count_reg       <= 7'd0;
      warm_cnt_reg    <= 2'd0;
      pend_reg        <= 1'b0;
      pend_sample_reg <= 16'h0000;
      pend_sat_reg    <= 1'b0;
      data_reg        <= 16'h0000;
      cnt_reg         <= 8'h00;
      warm_reg        <= 1'b0;
      sat_reg         <= 1'b0;
      valid_reg       <= 1'b0;
    end else if (ena) begin
      dec_sel_reg <= dec_sel;
      valid_reg   <= 1'b0;

      if (restart) begin
        // New ratio: flush the filter (including any sample in flight) but
        // keep the last reported bytes for the downstream mux.
        for (int i = 0; i < ORDER; i++) begin
          integ_reg[i]    <= '0;
          comb_dly_reg[i] <= '0;
        end
        act_sel_reg  <= dec_sel_reg;
        count_reg    <= 7'd0;
        warm_cnt_reg <= 2'd0;
        pend_reg     <= 1'b0;
        warm_reg     <= 1'b0;
      end else begin
        for (int i = 0; i < ORDER; i++) begin
          integ_reg[i] <= integ_next[i];
        end
        count_reg <= tick ? 7'd0 : count_reg + 7'd1;
        pend_reg  <= 1'b0;

        if (tick) begin
          for (int i = 0; i < ORDER; i++) begin
            comb_dly_reg[i] <= comb_val[i];
          end
          // The first two comb outputs are still settling and are dropped.
          if (warm_cnt_reg == 2'd2) begin
            pend_reg        <= 1'b1;
            pend_sample_reg <= scaled_sample;
            pend_sat_reg    <= scaled_sat;
          end else begin
            warm_cnt_reg <= warm_cnt_reg + 2'd1;
          end
        end

        // Report one enabled cycle after the tick; R >= 16 so this never
        // collides with the next tick.
        if (pend_reg) begin
          data_reg  <= pend_sample_reg;
          sat_reg   <= pend_sat_reg;
          warm_reg  <= 1'b1;
          cnt_reg   <= cnt_reg + 8'd1;
          valid_reg <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The pulse is gated rather than cleared while ena is low, so it
  // reappears on the first enabled cycle.
  // ---------------------------------------------------------------------------
  assign data_lo      = data_reg[7:0];
  assign data_hi      = data_reg[15:8];
  assign sample_cnt   = cnt_reg;
  assign status       = {warm_reg, sat_reg, act_sel_reg, 4'b0000};
  assign sample_valid = valid_reg & ena;

endmodule

// File: tb/tb_cic_decimator.sv
// -----------------------------------------------------------------------------
// tb_cic_decimator
//
// Directed bench for cic_decimator (default build). Expected values are hand
// derived: full-scale input gives a comb output of R^3, which scales to
// 0x10000 and saturates; an alternating 1,0 input gives R^3/2 -> 0x8000.
// A sample reported from tick edge T+0 loads one edge later, so the first
// report after (re)start appears 3*R+1 edges after the filter is cleared.
// -----------------------------------------------------------------------------
module tb_cic_decimator;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       ds_in;
  logic [1:0] dec_sel;
  logic [7:0] data_lo;
  logic [7:0] data_hi;
  logic [7:0] sample_cnt;
  logic [7:0] status;
  logic       sample_valid;

  logic ds_level;
  logic alt_en;
  logic alt_bit;

  int check_cnt = 0;
  int pass_cnt  = 0;

  assign ds_in = alt_en ? alt_bit : ds_level;

  cic_decimator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .ds_in        (ds_in),
    .dec_sel      (dec_sel),
    .data_lo      (data_lo),
    .data_hi      (data_hi),
    .sample_cnt   (sample_cnt),
    .status       (status),
    .sample_valid (sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Alternating bit source, changes 1 time unit after each rising edge.
  initial begin
    alt_bit = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      alt_bit = ~alt_bit;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("ok   %s: got 0x%0h", tag, got);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts rising edges until sample_valid is seen (bounded at 1000).
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!sample_valid && n < 1000);
  endtask

  int n;
  int pmin;
  int pmax;
  int any_valid;

  initial begin
    rst_n    = 1'b1;
    ena      = 1'b1;
    ds_level = 1'b0;
    alt_en   = 1'b0;
    dec_sel  = 2'b00;
    #2;
    rst_n = 1'b0;
    step(3);

    // Reset state
    check_val("reset_bytes", {data_hi, data_lo, sample_cnt, status}, 32'h0000_0000);
    check_val("reset_valid", 32'(sample_valid), 32'd0);

    // Full-scale input at R=16
    ds_level = 1'b1;
    rst_n    = 1'b1;
    wait_valid(n);
    check_val("first_report_latency", 32'(n), 32'd49);
    check_val("r16_data", 32'({data_hi, data_lo}), 32'h0000_FFFF);
    check_val("r16_status", 32'(status), 32'h0000_00C0);
    check_val("r16_cnt", 32'(sample_cnt), 32'd1);
    wait_valid(n);
    check_val("r16_period", 32'(n), 32'd16);
    check_val("r16_cnt2", 32'(sample_cnt), 32'd2);

    // 256 more reports -> 258 total, counter wraps to 0x02
    pmin = 1000;
    pmax = 0;
    for (int i = 0; i < 256; i++) begin
      wait_valid(n);
      if (n < pmin) pmin = n;
      if (n > pmax) pmax = n;
    end
    check_val("wrap_period_min", 32'(pmin), 32'd16);
    check_val("wrap_period_max", 32'(pmax), 32'd16);
    check_val("wrap_cnt", 32'(sample_cnt), 32'h02);
    check_val("wrap_data_status", {data_hi, data_lo, status}, 32'h00FF_FFC0);
    step(1);
    check_val("valid_one_cycle", 32'(sample_valid), 32'd0);

    // ena low across a pending pulse: everything holds, pulse comes back
    wait_valid(n);
    check_val("pre_freeze_period", 32'(n), 32'd15);
    ena = 1'b0;
    #1;
    check_val("valid_forced_low", 32'(sample_valid), 32'd0);
    any_valid = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (sample_valid) any_valid++;
    end
    check_val("freeze_no_valid", 32'(any_valid), 32'd0);
    check_val("freeze_outputs", {data_hi, data_lo, sample_cnt, status}, 32'hFFFF_03C0);
    ena = 1'b1;
    #1;
    check_val("pending_pulse_kept", 32'(sample_valid), 32'd1);
    wait_valid(n);
    check_val("post_freeze_period", 32'(n), 32'd16);
    check_val("post_freeze_cnt", 32'(sample_cnt), 32'd4);

    // Ratio change 00 -> 11 mid-block
    step(5);
    dec_sel = 2'b11;
    step(2);
    check_val("restart_status_bits", 32'(status & 8'hB0), 32'h30);
    check_val("restart_data_held", 32'({data_hi, data_lo}), 32'h0000_FFFF);
    check_val("restart_cnt_held", 32'(sample_cnt), 32'd4);
    wait_valid(n);
    check_val("r128_latency", 32'(n), 32'd385);
    check_val("r128_data", 32'({data_hi, data_lo}), 32'h0000_FFFF);
    check_val("r128_status", 32'(status), 32'h0000_00F0);
    check_val("r128_cnt", 32'(sample_cnt), 32'd5);

    // Zero input at R=64
    dec_sel  = 2'b10;
    ds_level = 1'b0;
    wait_valid(n);
    check_val("r64_latency", 32'(n), 32'd195);
    check_val("r64_zero_data", 32'({data_hi, data_lo}), 32'h0000_0000);
    check_val("r64_zero_status", 32'(status), 32'h0000_00A0);
    check_val("r64_zero_cnt", 32'(sample_cnt), 32'd6);

    // Alternating 1,0 at R=64 -> half scale, no saturation
    alt_en = 1'b1;
    repeat (4) wait_valid(n);
    check_val("alt_data", 32'({data_hi, data_lo}), 32'h0000_8000);
    check_val("alt_status", 32'(status), 32'h0000_00A0);
    check_val("alt_cnt", 32'(sample_cnt), 32'd10);

    // Asynchronous reset while the report pulse is high
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_bytes", {data_hi, data_lo, sample_cnt, status}, 32'h0000_0000);
    check_val("async_reset_valid", 32'(sample_valid), 32'd0);
    step(2);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
